// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the reaction-game round controller:
//   - state_e        : FSM state encoding (also driven out on the state port)
//   - LFSR_TAPS      : Fibonacci LFSR feedback mask (taps 8,6,5,4)
//   - MIN_SHOW_TICKS : lower bound of the shrinking show window
//   - ZERO_SUB_A/B   : substitutes used so an issued pattern is never zero
//   - lfsr_step()    : one LFSR advance
//   - sat_inc()      : 8-bit increment that sticks at 255
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SHOW = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [3:0] MIN_SHOW_TICKS = 4'd3;
  localparam logic [7:0] ZERO_SUB_A     = 8'h01;
  localparam logic [7:0] ZERO_SUB_B     = 8'h02;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_round_controller_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Divides the system clock down to a one-cycle tick. The count runs
//   0..DIV-1 while i_en is high and o_tick is high exactly while the count
//   sits at DIV-1. i_clr restarts the count at 0 and wins over i_en.
//   The tick is a register, decoded one count early, so the output is
//   glitch-free.
//
//   Parameters: DIV    clock cycles per tick, >= 2
//   Ports:      i_clk, i_rst_n (async, active-low)
//               i_en   count enable
//               i_clr  synchronous restart to 0
//               o_tick one-cycle tick pulse
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int unsigned DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] PRE  = W'(DIV - 2);

  logic [W-1:0] r_count;
  logic         r_tick;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + W'(1);
      r_tick  <= (r_count == PRE);
    end else begin
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller
//   Sequences one reaction game on top of the score calculator: generates the
//   tick, offers non-zero target patterns round by round, detects hit/miss
//   from the calculator's pattern echo and ends the game after ROUNDS rounds.
//
//   Optional feature macro: GAME_SPEEDUP_EN
//     defined   : show window = max(3, SHOW_TICKS - (round-1)/4), set in ARM
//     undefined : show window = SHOW_TICKS every round
//
//   Ports:
//     CLOCK50M      system clock
//     reset_n       asynchronous active-low reset
//     start         pulse, starts a game from IDLE/DONE
//     abort         pulse, returns to IDLE from any busy state
//     calc_pattern  pattern echoed by the score calculator
//     pattern       registered target pattern, 0 = none
//     counter10h    registered one-cycle tick pulse
//     state         FSM state encoding
//     round_cnt     rounds issued this game
//     hit_cnt       rounds hit
//     miss_cnt      rounds missed
//     busy          high in ARM/SHOW/GAP
//     game_over     high in DONE
// -----------------------------------------------------------------------------
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 10,
  parameter int unsigned ROUNDS     = 20,
  parameter int unsigned SHOW_TICKS = 10,
  parameter int unsigned GAP_TICKS  = 5,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       CLOCK50M,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] calc_pattern,
  output logic [7:0] pattern,
  output logic       counter10h,
  output logic [2:0] state,
  output logic [7:0] round_cnt,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic       busy,
  output logic       game_over
);

  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
  localparam logic [7:0]  ROUNDS_L = 8'(ROUNDS);
  localparam logic [3:0]  SHOW_L   = 4'(SHOW_TICKS);
  localparam logic [3:0]  GAP_L    = 4'(GAP_TICKS);

  state_e     r_state, w_state_next;
  logic [7:0] r_lfsr;
  logic [7:0] r_prev_pattern;
  logic [7:0] r_pattern;
  logic [7:0] r_round_cnt, r_hit_cnt, r_miss_cnt;
  logic [3:0] r_tick_cnt;
  logic       r_loaded;

  logic       w_busy, w_tick, w_div_en, w_div_clr;
  logic       w_start_game, w_do_arm, w_hit, w_miss, w_gap_end;
  logic [4:0] w_tick_inc;
  logic [7:0] w_cand;
  logic [3:0] w_show_win;

  assign w_busy = (r_state == ST_ARM) || (r_state == ST_SHOW) || (r_state == ST_GAP);

  // Divider is frozen as soon as an abort is seen so no tick leaks into IDLE;
  // every game entry into ARM restarts it from 0.
  assign w_div_en  = w_busy && !abort;
  assign w_div_clr = (w_state_next == ST_ARM) && (r_state != ST_ARM);

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .i_clk   (CLOCK50M),
    .i_rst_n (reset_n),
    .i_en    (w_div_en),
    .i_clr   (w_div_clr),
    .o_tick  (w_tick)
  );

`ifdef GAME_SPEEDUP_EN
  logic [3:0] r_show_win;
  logic [3:0] w_win_next;
  logic [7:0] w_round_next, w_shrink;

  // Window shrinks by one tick every four rounds, based on the round number
  // being issued in this ARM cycle.
  always_comb begin
    w_round_next = sat_inc(r_round_cnt);
    w_shrink     = (w_round_next - 8'd1) >> 2;
    if ({4'd0, SHOW_L} > ({4'd0, MIN_SHOW_TICKS} + w_shrink)) begin
      w_win_next = SHOW_L - w_shrink[3:0];
    end else begin
      w_win_next = MIN_SHOW_TICKS;
    end
  end

  always_ff @(posedge CLOCK50M or negedge reset_n) begin
    if (!reset_n) begin
      r_show_win <= SHOW_L;
    end else if (w_do_arm) begin
      r_show_win <= w_win_next;
    end
  end

  assign w_show_win = r_show_win;
`else
  assign w_show_win = SHOW_L;
`endif

  // Candidate pattern: never zero and never a repeat of the previous round.
  always_comb begin
    w_cand = (r_lfsr == 8'h00) ? ZERO_SUB_A : r_lfsr;
    if (w_cand == r_prev_pattern) begin
      w_cand = w_cand ^ 8'h01;
      if (w_cand == 8'h00) begin
        w_cand = ZERO_SUB_B;
      end
    end
  end

  always_ff @(posedge CLOCK50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_start_game = 1'b0;
    w_do_arm     = 1'b0;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_gap_end    = 1'b0;
    w_tick_inc   = {1'b0, r_tick_cnt} + 5'd1;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_game = 1'b1;
          w_state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        w_do_arm     = 1'b1;
        w_state_next = ST_SHOW;
      end
      ST_SHOW: begin
        // A hit on the timeout tick is still a hit.
        w_hit  = r_loaded && (calc_pattern == 8'h00);
        w_miss = !w_hit && w_tick && (w_tick_inc >= {1'b0, w_show_win});
        if (w_hit || w_miss) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_gap_end = w_tick && (w_tick_inc >= {1'b0, GAP_L});
        if (w_gap_end) begin
          w_state_next = (r_round_cnt == ROUNDS_L) ? ST_DONE : ST_ARM;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Abort outranks everything: the current round is neither hit nor miss.
    if (abort && w_busy) begin
      w_state_next = ST_IDLE;
      w_do_arm     = 1'b0;
      w_hit        = 1'b0;
      w_miss       = 1'b0;
      w_gap_end    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK50M or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr         <= LFSR_SEED;
      r_prev_pattern <= 8'h00;
      r_pattern      <= 8'h00;
      r_round_cnt    <= 8'h00;
      r_hit_cnt      <= 8'h00;
      r_miss_cnt     <= 8'h00;
      r_tick_cnt     <= 4'd0;
      r_loaded       <= 1'b0;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);

      if (w_start_game) begin
        r_round_cnt <= 8'h00;
        r_hit_cnt   <= 8'h00;
        r_miss_cnt  <= 8'h00;
      end
      if (w_do_arm) begin
        r_round_cnt    <= sat_inc(r_round_cnt);
        r_prev_pattern <= w_cand;
      end
      if (w_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end
      if (w_miss) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end

      // Pattern is only non-zero while SHOW is the next state.
      if (w_state_next == ST_SHOW) begin
        r_pattern <= w_do_arm ? w_cand : r_pattern;
      end else begin
        r_pattern <= 8'h00;
      end

      // Tick counter is per-state: restarts on every state change.
      if (w_state_next != r_state) begin
        r_tick_cnt <= 4'd0;
      end else if (w_tick) begin
        r_tick_cnt <= w_tick_inc[3:0];
      end

      if (w_do_arm) begin
        r_loaded <= 1'b0;
      end else if ((r_state == ST_SHOW) && (calc_pattern == r_pattern)) begin
        r_loaded <= 1'b1;
      end
    end
  end

  assign pattern    = r_pattern;
  assign counter10h = w_tick;
  assign state      = r_state;
  assign round_cnt  = r_round_cnt;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign busy       = w_busy;
  assign game_over  = (r_state == ST_DONE);

endmodule

// File: tb/tb_game_round_controller.sv
// -----------------------------------------------------------------------------
// tb_game_round_controller
//   Directed bench. dut: DIV=10, ROUNDS=3, SHOW_TICKS=4, GAP_TICKS=2.
//   dut2: DIV=10, ROUNDS=12, SHOW_TICKS=10, GAP_TICKS=1 for the show window.
//   Cycle numbers in comments count from the first ARM cycle (c0).
// -----------------------------------------------------------------------------
module tb_game_round_controller;

`ifdef GAME_SPEEDUP_EN
  localparam int WIN12 = 8;
`else
  localparam int WIN12 = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] calc_pattern = 8'h00;
  logic [7:0] pattern, round_cnt, hit_cnt, miss_cnt;
  logic [2:0] state;
  logic       counter10h, busy, game_over;

  logic       start_2 = 1'b0;
  logic       abort_2 = 1'b0;
  logic [7:0] calc_pattern_2 = 8'h00;
  logic [7:0] pattern_2, round_cnt_2, hit_cnt_2, miss_cnt_2;
  logic [2:0] state_2;
  logic       counter10h_2, busy_2, game_over_2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_round_controller #(
    .CLK_HZ(100), .TICK_HZ(10), .ROUNDS(3), .SHOW_TICKS(4), .GAP_TICKS(2),
    .LFSR_SEED(8'hA5)
  ) dut (
    .CLOCK50M(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .calc_pattern(calc_pattern), .pattern(pattern), .counter10h(counter10h),
    .state(state), .round_cnt(round_cnt), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .busy(busy), .game_over(game_over)
  );

  game_round_controller #(
    .CLK_HZ(100), .TICK_HZ(10), .ROUNDS(12), .SHOW_TICKS(10), .GAP_TICKS(1),
    .LFSR_SEED(8'hA5)
  ) dut2 (
    .CLOCK50M(clk), .reset_n(rst_n), .start(start_2), .abort(abort_2),
    .calc_pattern(calc_pattern_2), .pattern(pattern_2), .counter10h(counter10h_2),
    .state(state_2), .round_cnt(round_cnt_2), .hit_cnt(hit_cnt_2),
    .miss_cnt(miss_cnt_2), .busy(busy_2), .game_over(game_over_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // From a negedge, step negedges until state==tgt (bounded).
  task automatic wait_state(input logic [2:0] tgt, input int max_cyc, output int cyc);
    cyc = 0;
    while (state !== tgt && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // From a negedge, step negedges until counter10h is seen (bounded).
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (counter10h !== 1'b1 && cyc < 50);
  endtask

  initial begin
    int cyc;
    int ticks;

    // ---------------- reset ----------------
    #23;
    check("rst_state",   32'(state), 32'd0);
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_counts",  32'({round_cnt, hit_cnt, miss_cnt}), 32'd0);
    check("rst_flags",   32'({counter10h, busy, game_over}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- game 1, round 1: hit ----------------
    force dut.r_lfsr = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);                                  // c0 ARM
    check("arm_state", 32'(state), 32'd1);
    check("arm_busy",  32'(busy), 32'd1);
    check("arm_round", 32'(round_cnt), 32'd0);
    @(posedge clk);
    #1 release dut.r_lfsr;
    @(negedge clk);                                  // c1 SHOW
    check("show_state",   32'(state), 32'd2);
    check("show_pattern", 32'(pattern), 32'h3C);
    check("show_round",   32'(round_cnt), 32'd1);
    wait_tick(cyc);                                  // c9
    check("first_tick_cycles", 32'(cyc), 32'd8);
    calc_pattern = 8'h3C;
    wait_tick(cyc);                                  // c19
    check("tick_period", 32'(cyc), 32'd10);
    calc_pattern = 8'h00;
    @(negedge clk);                                  // c20 GAP
    check("hit_state",   32'(state), 32'd3);
    check("hit_counts",  32'({hit_cnt, miss_cnt}), 32'h0100);
    check("gap_pattern", 32'(pattern), 32'd0);
    wait_state(3'd1, 100, cyc);                      // c40 ARM
    check("gap_length", 32'(cyc), 32'd20);

    // ---------------- round 2: repeat avoidance, miss ----------------
    force dut.r_lfsr = 8'h3C;
    @(posedge clk);
    #1 release dut.r_lfsr;
    @(negedge clk);                                  // c41
    check("repeat_pattern", 32'(pattern), 32'h3D);
    check("round2_cnt",     32'(round_cnt), 32'd2);
    ticks = 0;
    cyc   = 0;
    while (state === 3'd2 && cyc < 200) begin
      if (counter10h === 1'b1) ticks++;
      @(negedge clk);
      cyc++;
    end                                              // c80 GAP
    check("miss_window_ticks", 32'(ticks), 32'd4);
    check("miss_state",  32'(state), 32'd3);
    check("miss_counts", 32'({hit_cnt, miss_cnt}), 32'h0101);
    wait_state(3'd1, 100, cyc);                      // c100 ARM
    check("gap2_length", 32'(cyc), 32'd20);

    // ---------------- round 3: zero LFSR, hit on timeout tick ----------------
    force dut.r_lfsr = 8'h00;
    @(posedge clk);
    #1 release dut.r_lfsr;
    @(negedge clk);                                  // c101
    check("zero_pattern", 32'(pattern), 32'h01);
    calc_pattern = 8'h01;
    ticks = 0;
    cyc   = 0;
    while (ticks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (counter10h === 1'b1) ticks++;
    end                                              // c139, 4th tick
    calc_pattern = 8'h00;
    @(negedge clk);                                  // c140
    check("hit_timeout_state",  32'(state), 32'd3);
    check("hit_timeout_counts", 32'({hit_cnt, miss_cnt}), 32'h0201);
    wait_state(3'd4, 100, cyc);                      // c160 DONE
    check("done_delay",   32'(cyc), 32'd20);
    check("done_flags",   32'({game_over, busy}), 32'b10);
    check("done_total",   32'(hit_cnt + miss_cnt), 32'd3);
    check("done_round",   32'(round_cnt), 32'd3);
    check("done_pattern", 32'(pattern), 32'd0);
    ticks = 0;
    repeat (30) begin
      @(negedge clk);
      if (counter10h === 1'b1) ticks++;
    end
    check("done_no_ticks", 32'(ticks), 32'd0);
    check("done_frozen",   32'({round_cnt, hit_cnt, miss_cnt}), 32'h030201);

    // ---------------- game 2: 01^01 -> 02, start ignored, abort ----------------
    @(negedge clk);
    force dut.r_lfsr = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("restart_cleared", 32'({round_cnt, hit_cnt, miss_cnt}), 32'd0);
    @(posedge clk);
    #1 release dut.r_lfsr;
    @(negedge clk);
    check("double_sub_pattern", 32'(pattern), 32'h02);
    pulse_start();
    @(negedge clk);
    check("start_ignored", 32'({state, round_cnt}), 32'({3'd2, 8'd1}));
    calc_pattern = 8'h02;
    @(negedge clk);
    calc_pattern = 8'h00;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_state",   32'(state), 32'd0);
    check("abort_pattern", 32'(pattern), 32'd0);
    check("abort_counts",  32'({round_cnt, hit_cnt, miss_cnt}), 32'h010000);
    check("abort_busy",    32'(busy), 32'd0);
    ticks = 0;
    repeat (25) begin
      @(negedge clk);
      if (counter10h === 1'b1) ticks++;
    end
    check("abort_div_stopped", 32'(ticks), 32'd0);

    // ---------------- async reset mid-SHOW ----------------
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_show", 32'(state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_outs",  32'({pattern, round_cnt, busy, counter10h}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- dut2: show window over 12 rounds ----------------
    @(negedge clk);
    start_2 = 1'b1;
    @(posedge clk);
    #1 start_2 = 1'b0;
    cyc = 0;
    while (state_2 !== 3'd2 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    ticks = 0;
    cyc   = 0;
    while (state_2 === 3'd2 && cyc < 300) begin
      if (counter10h_2 === 1'b1) ticks++;
      @(negedge clk);
      cyc++;
    end
    check("win_round1", 32'(ticks), 32'd10);
    cyc = 0;
    while (!(state_2 === 3'd2 && round_cnt_2 === 8'd12) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_round12", 32'(round_cnt_2), 32'd12);
    ticks = 0;
    cyc   = 0;
    while (state_2 === 3'd2 && cyc < 300) begin
      if (counter10h_2 === 1'b1) ticks++;
      @(negedge clk);
      cyc++;
    end
    check("win_round12", 32'(ticks), 32'(WIN12));
    cyc = 0;
    while (state_2 !== 3'd4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("dut2_done", 32'({game_over_2, busy_2, pattern_2}), 32'({1'b1, 1'b0, 8'h00}));
    check("dut2_counts", 32'({hit_cnt_2, miss_cnt_2}), 32'h000C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
